// File: rtl/multi_clock_gater_pkg.sv
// Shared power-mode encoding for the clock gater and its requesters.

package multi_clock_gater_pkg;

    // Per-domain power mode; 2'b11 is unassigned and read as NORMAL by consumers
    typedef enum logic [1:0] {
        SHUTDOWN = 2'b00,
        LP       = 2'b01,
        NORMAL   = 2'b10
    } powermode_t;

endpackage

// File: rtl/multi_clock_gater.sv
// Multi-channel glitch-free clock divider/gater. Each channel owns a power
// mode, a divide counter and a registered output clock. Mode changes are
// deferred to a falling edge of the channel clock so no runt pulse escapes.

module multi_clock_gater
    import multi_clock_gater_pkg::*;
#(
    parameter int unsigned NCH         = 4,
    parameter int unsigned CW          = 4,
    parameter int unsigned NORMAL_DIV  = 0,
    parameter int unsigned LP_DIV      = 1,
    parameter int unsigned WAKE_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic       [NCH-1:0] req_valid,
    input  powermode_t [NCH-1:0] p_req,
    output logic       [NCH-1:0] req_ready,
    output logic       [NCH-1:0] oclk,
    output powermode_t [NCH-1:0] cur_mode,
    output logic       [NCH-1:0] active
);

    localparam logic [CW-1:0] NORMAL_CNT = CW'(NORMAL_DIV);
    localparam logic [CW-1:0] LP_CNT     = CW'(LP_DIV);
    localparam logic [CW-1:0] WAKE_LAST  = CW'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_WAKE  = 2'b01,
        ST_RUN   = 2'b10,
        ST_DRAIN = 2'b11
    } state_t;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t        state;
        logic [CW-1:0] cnt;
        powermode_t    pend;
        powermode_t    mode_q;
        logic          oclk_q;
        logic          active_q;
        logic [CW-1:0] div_c;
        powermode_t    req_mode_c;
        logic          ready_c;
        logic          accept_c;
        logic          tick_c;

        // Divider select, request normalisation and handshake decode
        always_comb begin
            div_c      = (mode_q == NORMAL) ? NORMAL_CNT : LP_CNT;
            req_mode_c = ((p_req[g] == SHUTDOWN) || (p_req[g] == LP)) ? p_req[g] : NORMAL;
            ready_c    = (state == ST_OFF) || (state == ST_RUN);
            accept_c   = req_valid[g] && ready_c;
            tick_c     = (cnt == div_c);
        end

        // Channel FSM: wake settle, divide/toggle, drain to a falling edge
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= ST_OFF;
                cnt      <= '0;
                pend     <= SHUTDOWN;
                mode_q   <= SHUTDOWN;
                oclk_q   <= 1'b0;
                active_q <= 1'b0;
            end else begin
                active_q <= (state == ST_RUN) || (state == ST_DRAIN);
                unique case (state)
                    ST_OFF: begin
                        oclk_q <= 1'b0;
                        cnt    <= '0;
                        if (accept_c && (req_mode_c != SHUTDOWN)) begin
                            pend  <= req_mode_c;
                            state <= ST_WAKE;
                        end
                    end
                    ST_WAKE: begin
                        oclk_q <= 1'b0;
                        if (cnt == WAKE_LAST) begin
                            mode_q <= pend;
                            cnt    <= '0;
                            state  <= ST_RUN;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ST_RUN: begin
                        if (tick_c) begin
                            oclk_q <= ~oclk_q;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                        if (accept_c && (req_mode_c != mode_q)) begin
                            pend  <= req_mode_c;
                            state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        // Keep the old divider until the falling toggle, then switch
                        if (tick_c) begin
                            oclk_q <= ~oclk_q;
                            cnt    <= '0;
                            if (oclk_q) begin
                                if (pend == SHUTDOWN) begin
                                    mode_q <= SHUTDOWN;
                                    state  <= ST_OFF;
                                end else begin
                                    mode_q <= pend;
                                    state  <= ST_RUN;
                                end
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: state <= ST_OFF;
                endcase
            end
        end

        assign req_ready[g] = ready_c;
        assign oclk[g]      = oclk_q;
        assign cur_mode[g]  = mode_q;
        assign active[g]    = active_q;
    end

endmodule

// File: tb/tb_multi_clock_gater.sv
// Bench for multi_clock_gater: timeline model of each channel plus pinned
// literal expectations for wake, mode switch, shutdown, concurrency and reset.
`timescale 1ns/1ps

module tb_multi_clock_gater;
    import multi_clock_gater_pkg::*;

    localparam int NCH         = 4;
    localparam int CW          = 4;
    localparam int NORMAL_DIV  = 0;
    localparam int LP_DIV      = 1;
    localparam int WAKE_CYCLES = 3;

    localparam int M_OFF   = 0;
    localparam int M_WAKE  = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic       [NCH-1:0] req_valid = '0;
    powermode_t [NCH-1:0] p_req;
    logic       [NCH-1:0] req_ready;
    logic       [NCH-1:0] oclk;
    powermode_t [NCH-1:0] cur_mode;
    logic       [NCH-1:0] active;

    always #5 clk = ~clk;

    multi_clock_gater #(
        .NCH(NCH), .CW(CW), .NORMAL_DIV(NORMAL_DIV),
        .LP_DIV(LP_DIV), .WAKE_CYCLES(WAKE_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .p_req(p_req),
        .req_ready(req_ready), .oclk(oclk), .cur_mode(cur_mode), .active(active)
    );

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    // Model: phase label plus timestamps (run start edge, drain finish edge)
    int         m_st   [NCH];
    int         m_t0   [NCH];
    int         m_tf   [NCH];
    powermode_t m_cur  [NCH];
    powermode_t m_pend [NCH];
    bit         m_act  [NCH];

    function automatic int half_period(input powermode_t m);
        return (m == NORMAL) ? NORMAL_DIV + 1 : LP_DIV + 1;
    endfunction

    function automatic powermode_t norm_mode(input powermode_t m);
        return (m == SHUTDOWN || m == LP) ? m : NORMAL;
    endfunction

    function automatic bit m_ready(input int c);
        return (m_st[c] == M_OFF) || (m_st[c] == M_RUN);
    endfunction

    // oclk is high after an odd number of half periods since the run started
    function automatic bit m_oclk(input int c);
        if (m_st[c] == M_RUN || m_st[c] == M_DRAIN)
            return (((edge_n - m_t0[c]) / half_period(m_cur[c])) % 2) == 1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_st[c]   = M_OFF;
            m_t0[c]   = 0;
            m_tf[c]   = 0;
            m_cur[c]  = SHUTDOWN;
            m_pend[c] = SHUTDOWN;
            m_act[c]  = 1'b0;
        end
    endtask

    task automatic model_edge(output logic [NCH-1:0] acc);
        edge_n++;
        for (int c = 0; c < NCH; c++) begin
            powermode_t rq;
            int h;
            int m;
            rq     = norm_mode(p_req[c]);
            acc[c] = req_valid[c] && m_ready(c);
            m_act[c] = (m_st[c] == M_RUN) || (m_st[c] == M_DRAIN);
            case (m_st[c])
                M_OFF: if (acc[c] && rq != SHUTDOWN) begin
                    m_st[c]   = M_WAKE;
                    m_pend[c] = rq;
                    m_t0[c]   = edge_n + WAKE_CYCLES;
                end
                M_WAKE: if (edge_n == m_t0[c]) begin
                    m_st[c]  = M_RUN;
                    m_cur[c] = m_pend[c];
                end
                M_RUN: if (acc[c] && rq != m_cur[c]) begin
                    // Switch lands on the first falling toggle strictly after this edge
                    m_st[c]   = M_DRAIN;
                    m_pend[c] = rq;
                    h = half_period(m_cur[c]);
                    m = (edge_n - m_t0[c]) / h + 1;
                    if (m % 2 == 1) m++;
                    m_tf[c] = m_t0[c] + m * h;
                end
                default: if (edge_n == m_tf[c]) begin
                    if (m_pend[c] == SHUTDOWN) begin
                        m_st[c]  = M_OFF;
                        m_cur[c] = SHUTDOWN;
                    end else begin
                        m_st[c]  = M_RUN;
                        m_cur[c] = m_pend[c];
                        m_t0[c]  = edge_n;
                    end
                end
            endcase
        end
    endtask

    task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s ch%0d edge=%0d got=%0h want=%0h", name, c, edge_n, got, want);
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < NCH; c++) begin
            chk("oclk", c, 32'(oclk[c]), 32'(m_oclk(c)));
            chk("req_ready", c, 32'(req_ready[c]), 32'(m_ready(c)));
            chk("cur_mode", c, 32'(cur_mode[c]), 32'(m_cur[c]));
            chk("active", c, 32'(active[c]), 32'(m_act[c]));
        end
    endtask

    // One source-clock cycle: model follows the edge, outputs compared on the falling edge
    task automatic step();
        logic [NCH-1:0] acc;
        @(posedge clk);
        model_edge(acc);
        @(negedge clk);
        compare_all();
        for (int c = 0; c < NCH; c++)
            if (acc[c]) req_valid[c] = 1'b0;
    endtask

    task automatic run_to(input int e);
        while (edge_n < e) step();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        for (int c = 0; c < NCH; c++) begin
            chk("rst_oclk", c, 32'(oclk[c]), 32'd0);
            chk("rst_ready", c, 32'(req_ready[c]), 32'd1);
        end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) p_req[c] = SHUTDOWN;
        model_reset();
        #1;
        compare_all();
        chk("reset_mode", 0, 32'(cur_mode[0]), 32'(SHUTDOWN));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle, then wake ch0 to NORMAL at edge 10
        run_to(9);
        chk("idle_oclk", 0, 32'(oclk), 32'd0);
        req_valid[0] = 1'b1; p_req[0] = NORMAL;
        run_to(10); chk("wake_ready", 0, 32'(req_ready[0]), 32'd0);
        run_to(12); chk("wake_mode", 0, 32'(cur_mode[0]), 32'(SHUTDOWN));
        run_to(13); chk("run_mode", 0, 32'(cur_mode[0]), 32'(NORMAL));
                    chk("run_oclk13", 0, 32'(oclk[0]), 32'd0);
                    chk("run_ready", 0, 32'(req_ready[0]), 32'd1);
        run_to(14); chk("first_rise", 0, 32'(oclk[0]), 32'd1);
                    chk("active_rise", 0, 32'(active[0]), 32'd1);
        run_to(15); chk("oclk15", 0, 32'(oclk[0]), 32'd0);
        run_to(16); chk("oclk16", 0, 32'(oclk[0]), 32'd1);

        // NORMAL -> LP, accepted at edge 17, switch at falling edge 19
        req_valid[0] = 1'b1; p_req[0] = LP;
        run_to(17); chk("drain_ready17", 0, 32'(req_ready[0]), 32'd0);
        run_to(18); chk("drain_oclk18", 0, 32'(oclk[0]), 32'd1);
                    chk("drain_mode18", 0, 32'(cur_mode[0]), 32'(NORMAL));
        run_to(19); chk("switch_oclk", 0, 32'(oclk[0]), 32'd0);
                    chk("switch_mode", 0, 32'(cur_mode[0]), 32'(LP));
                    chk("switch_ready", 0, 32'(req_ready[0]), 32'd1);
        run_to(21); chk("lp_rise", 0, 32'(oclk[0]), 32'd1);
        run_to(22); chk("lp_high2", 0, 32'(oclk[0]), 32'd1);
        run_to(23); chk("lp_fall", 0, 32'(oclk[0]), 32'd0);

        // LP -> SHUTDOWN, accepted at edge 24, off at falling edge 27
        req_valid[0] = 1'b1; p_req[0] = SHUTDOWN;
        run_to(24); chk("sd_ready", 0, 32'(req_ready[0]), 32'd0);
        run_to(26); chk("sd_high", 0, 32'(oclk[0]), 32'd1);
        run_to(27); chk("sd_fall", 0, 32'(oclk[0]), 32'd0);
                    chk("sd_mode", 0, 32'(cur_mode[0]), 32'(SHUTDOWN));
                    chk("sd_ready_back", 0, 32'(req_ready[0]), 32'd1);
        run_to(28); chk("sd_active", 0, 32'(active[0]), 32'd0);

        // All channels request at once; ch2 uses the unassigned encoding
        req_valid = '1;
        p_req[0] = NORMAL; p_req[1] = LP; p_req[2] = powermode_t'(2'b11); p_req[3] = SHUTDOWN;
        run_to(29); chk("cc_ready3", 3, 32'(req_ready[3]), 32'd1);
                    chk("cc_ready2", 2, 32'(req_ready[2]), 32'd0);
        run_to(32); chk("cc_unknown", 2, 32'(cur_mode[2]), 32'(NORMAL));
                    chk("cc_lp", 1, 32'(cur_mode[1]), 32'(LP));
        run_to(33); chk("cc_ch1_low", 1, 32'(oclk[1]), 32'd0);
        req_valid[1] = 1'b1; p_req[1] = LP;
        run_to(34); chk("same_ready", 1, 32'(req_ready[1]), 32'd1);
                    chk("same_oclk", 1, 32'(oclk[1]), 32'd1);
        run_to(36); chk("same_fall", 1, 32'(oclk[1]), 32'd0);

        // Put ch0 into DRAIN and ch3 into WAKE, then reset
        req_valid[0] = 1'b1; p_req[0] = LP;
        req_valid[3] = 1'b1; p_req[3] = NORMAL;
        run_to(37); chk("pre_rst_ready0", 0, 32'(req_ready[0]), 32'd0);
                    chk("pre_rst_ready3", 3, 32'(req_ready[3]), 32'd0);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("quiet_after_rst", 0, 32'(oclk), 32'd0);
        end

        // Randomised requests with occasional resets
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!req_valid[c] && $urandom_range(0, 3) == 0) begin
                    req_valid[c] = 1'b1;
                    p_req[c] = powermode_t'(2'($urandom_range(0, 3)));
                end
            end
            if ($urandom_range(0, 249) == 0) do_reset();
            else step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
